ov7670_stream_gen: RTL and testbench

Synthetic OV7670 sensor transmitter. It generates the `vsync` / `href` / `d[7:0]` byte stream that `ov7670_capture` consumes, in RGB444 two-bytes-per-pixel format, at one byte per clock. It replaces the real camera in simulation and in on-board bring-up of the capture → frame_buffer → VGA path. It offers selectable test patterns and frame-level status outputs.

---
 rtl/ov7670_stream_gen_if.sv | 22 ++
 rtl/ov7670_stream_gen.sv | 212 +++++++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_stream_gen_if.sv
// Control/status and sensor-side byte stream of the synthetic OV7670 transmitter.
// master = generator side, slave = controller / capture side.
interface ov7670_stream_gen_if;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [11:0] solid_rgb;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic        frame_done;
  logic [15:0] frame_count;

  modport master (
    input  enable, pattern_sel, solid_rgb,
    output vsync, href, d, frame_done, frame_count
  );

  modport slave (
    output enable, pattern_sel, solid_rgb,
    input  vsync, href, d, frame_done, frame_count
  );
endinterface

// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 RGB444 source: vsync/href/d at one byte per clock, selectable test patterns.
// Latency: registered outputs reflect the current FSM cycle; free-running source, no backpressure.
module ov7670_stream_gen #(
  parameter int ACTIVE_W    = 320,
  parameter int ACTIVE_H    = 240,
  parameter int HBLANK      = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP         = 17,
  parameter int VFP         = 10
) (
  input  logic                clk,
  input  logic                reset,
  ov7670_stream_gen_if.master bus
);

  localparam int LINE_T      = 2 * ACTIVE_W + HBLANK;
  localparam int FRAME_LINES = VSYNC_LINES + VBP + ACTIVE_H + VFP;
  localparam int CW          = $clog2(LINE_T);
  localparam int LW0         = $clog2(FRAME_LINES + 1);
  localparam int LW          = (LW0 < 4) ? 4 : LW0;
  localparam int BAR_PX      = ACTIVE_W / 8;
  localparam int SW          = (BAR_PX > 1) ? $clog2(BAR_PX) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(LINE_T - 1);
  localparam logic [CW-1:0] COL_HREF = CW'(2 * ACTIVE_W);
  localparam logic [LW-1:0] VS_L     = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VBP_L    = LW'((VBP > 0) ? VBP - 1 : 0);
  localparam logic [LW-1:0] ACT_L    = LW'(ACTIVE_H - 1);
  localparam logic [LW-1:0] VFP_L    = LW'((VFP > 0) ? VFP - 1 : 0);
  localparam logic [SW-1:0] SEG_LAST = SW'(BAR_PX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_VFP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] ln_q, ln_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [2:0]    bar_q, bar_d;
  logic [1:0]    pat_q, pat_d;
  logic [11:0]   rgb_q, rgb_d;
  logic [3:0]    fcl_q, fcl_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    d_q, d_d;
  logic          frame_done_q, frame_done_d;

  logic          eol;
  logic          eop;
  logic          frame_end;
  logic          start_frame;
  logic [3:0]    x4;
  logic [3:0]    y4;
  logic [11:0]   px;

  function automatic logic [LW-1:0] phase_last(state_t s);
    case (s)
      S_VSYNC:  return VS_L;
      S_VBP:    return VBP_L;
      S_ACTIVE: return ACT_L;
      S_VFP:    return VFP_L;
      default:  return '0;
    endcase
  endfunction

  // Final cycle of a frame: last VFP cycle, or last active-line cycle when there is no VFP.
  function automatic logic is_last(state_t s, logic [CW-1:0] c, logic [LW-1:0] l);
    if (c != COL_LAST) return 1'b0;
    if (s == S_VFP) return (l == VFP_L);
    return (VFP == 0) && (s == S_ACTIVE) && (l == ACT_L);
  endfunction

  function automatic logic [11:0] bar_rgb(logic [2:0] b);
    case (b)
      3'd0:    return 12'hFFF;
      3'd1:    return 12'hFF0;
      3'd2:    return 12'h0FF;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'hF0F;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    ln_d          = ln_q;
    pat_d         = pat_q;
    rgb_d         = rgb_q;
    fcl_d         = fcl_q;
    frame_count_d = frame_count_q;
    start_frame   = 1'b0;
    eol           = (col_q == COL_LAST);
    eop           = eol && (ln_q == phase_last(state_q));
    frame_end     = is_last(state_q, col_q, ln_q);

    if (state_q != S_IDLE) begin
      col_d = eol ? '0 : col_q + 1'b1;
      if (eol) begin
        ln_d = eop ? '0 : ln_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE:   if (bus.enable) start_frame = 1'b1;
      S_VSYNC:  if (eop) state_d = (VBP > 0) ? S_VBP : S_ACTIVE;
      S_VBP:    if (eop) state_d = S_ACTIVE;
      S_ACTIVE: if (eop && (VFP > 0)) state_d = S_VFP;
      default:  ;
    endcase

    if (frame_end) begin
      frame_count_d = frame_count_q + 16'd1;
      if (bus.enable) start_frame = 1'b1;
      else            state_d     = S_IDLE;
    end

    // Pattern controls and the ramp's blue value are frozen for the whole frame.
    if (start_frame) begin
      state_d = S_VSYNC;
      col_d   = '0;
      ln_d    = '0;
      pat_d   = bus.pattern_sel;
      rgb_d   = bus.solid_rgb;
      fcl_d   = frame_count_d[3:0];
    end
  end

  // Bar index tracks the pixel at col_d; steps every BAR_PX pixels instead of dividing x.
  always_comb begin
    seg_d = seg_q;
    bar_d = bar_q;
    if (col_d == '0) begin
      seg_d = '0;
      bar_d = '0;
    end else if (!col_d[0]) begin
      if (seg_q == SEG_LAST) begin
        seg_d = '0;
        bar_d = bar_q + 3'd1;
      end else begin
        seg_d = seg_q + 1'b1;
      end
    end
  end

  always_comb begin
    x4 = col_d[4:1];
    y4 = ln_d[3:0];
    px = 12'h000;
    case (pat_d)
      2'd0:    px = bar_rgb(bar_d);
      2'd1:    px = {x4, y4, fcl_d};
      2'd2:    px = rgb_d;
      default: px = (x4[3] ^ y4[3]) ? rgb_d : 12'h000;
    endcase

    vsync_d      = (state_d == S_VSYNC);
    href_d       = (state_d == S_ACTIVE) && (col_d < COL_HREF);
    d_d          = 8'h00;
    if (href_d) begin
      d_d = col_d[0] ? px[7:0] : {4'h0, px[11:8]};
    end
    frame_done_d = is_last(state_d, col_d, ln_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      ln_q          <= '0;
      seg_q         <= '0;
      bar_q         <= '0;
      pat_q         <= '0;
      rgb_q         <= '0;
      fcl_q         <= '0;
      frame_count_q <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      d_q           <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      ln_q          <= ln_d;
      seg_q         <= seg_d;
      bar_q         <= bar_d;
      pat_q         <= pat_d;
      rgb_q         <= rgb_d;
      fcl_q         <= fcl_d;
      frame_count_q <= frame_count_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      d_q           <= d_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.vsync       = vsync_q;
  assign bus.href        = href_q;
  assign bus.d           = d_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: per-cycle scoreboard against an arithmetic frame model,
// plus a pixel-probe vector table and reset/enable corner sequences.
module tb_ov7670_stream_gen;

  localparam int W  = 16;
  localparam int H  = 4;
  localparam int HB = 4;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int LT = 2 * W + HB;
  localparam int FT = LT * (VS + VB + H + VF);

  typedef struct packed {
    logic        vs;
    logic        hr;
    logic [7:0]  d;
    logic        fd;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    logic [1:0]  pat;
    logic [11:0] rgb;
    int          x;
    int          y;
    logic [15:0] bytes;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ov7670_stream_gen_if sif ();

  ov7670_stream_gen #(
    .ACTIVE_W(W), .ACTIVE_H(H), .HBLANK(HB),
    .VSYNC_LINES(VS), .VBP(VB), .VFP(VF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sif)
  );

  int   total = 0;
  int   bad   = 0;
  int   pop_cnt = 0;
  obs_t exp_q[$];
  obs_t act[0:1023];
  vec_t vt[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [11:0] bar_colour(input int b);
    case (b)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic obs_t zrec(input int fc);
    obs_t o;
    o    = '0;
    o.fc = 16'(fc);
    return o;
  endfunction

  // Expected outputs at cycle t of a frame, from row/column arithmetic.
  function automatic obs_t model(input int t, input logic [1:0] pat, input logic [11:0] rgb, input int fc);
    obs_t        o;
    int          row, col, x, y;
    logic [11:0] px;
    o    = zrec(fc);
    row  = t / LT;
    col  = t % LT;
    o.vs = (row < VS);
    o.fd = (t == FT - 1);
    if (row >= VS + VB && row < VS + VB + H && col < 2 * W) begin
      x = col / 2;
      y = row - VS - VB;
      case (pat)
        2'd0:    px = bar_colour(x / (W / 8));
        2'd1:    px = {x[3:0], y[3:0], fc[3:0]};
        2'd2:    px = rgb;
        default: px = (((x / 8) % 2) != ((y / 8) % 2)) ? rgb : 12'h000;
      endcase
      o.hr = 1'b1;
      o.d  = (col % 2 == 1) ? px[7:0] : {4'h0, px[11:8]};
    end
    return o;
  endfunction

  task automatic push_frame(input int fc, input logic [1:0] pat, input logic [11:0] rgb);
    for (int t = 0; t < FT; t++) exp_q.push_back(model(t, pat, rgb, fc));
  endtask

  task automatic step(input string name);
    obs_t a, e;
    @(posedge clk);
    #1;
    a.vs = sif.vsync;
    a.hr = sif.href;
    a.d  = sif.d;
    a.fd = sif.frame_done;
    a.fc = sif.frame_count;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (pop_cnt < 1024) act[pop_cnt] = a;
      pop_cnt++;
      check(name, {5'b0, a}, {5'b0, e});
    end
    check({name, "_excl"}, {31'b0, a.vs & a.hr}, 32'b0);
  endtask

  task automatic do_reset(input int n);
    exp_q.delete();
    pop_cnt = 0;
    reset   = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(zrec(0));
    for (int i = 0; i < n; i++) step("reset");
    reset = 1'b0;
  endtask

  // n frames; mid-way through the last one enable drops and the pattern inputs change.
  task automatic run_frames(input int n, input logic [1:0] pat, input logic [11:0] rgb,
                            input int fc0, input string name);
    sif.pattern_sel = pat;
    sif.solid_rgb   = rgb;
    sif.enable      = 1'b1;
    exp_q.delete();
    pop_cnt = 0;
    for (int k = 0; k < n; k++) push_frame(fc0 + k, pat, rgb);
    for (int j = 0; j < 3; j++) exp_q.push_back(zrec(fc0 + n));
    for (int s = 0; s < n * FT + 3; s++) begin
      if (s == (n - 1) * FT + 100) begin
        sif.enable      = 1'b0;
        sif.pattern_sel = pat + 2'd1;
        sif.solid_rgb   = ~rgb;
      end
      step(name);
    end
  endtask

  function automatic int pix_t(input int f, input int x, input int y);
    return f * FT + (VS + VB + y) * LT + 2 * x;
  endfunction

  initial begin
    int          wr;
    int          ph;
    int          ti;
    logic [3:0]  hi;

    vt[0]  = '{2'd0, 12'h000, 0,  0, 16'h0FFF};
    vt[1]  = '{2'd0, 12'h000, 2,  1, 16'h0FF0};
    vt[2]  = '{2'd0, 12'h000, 4,  3, 16'h00FF};
    vt[3]  = '{2'd0, 12'h000, 6,  0, 16'h00F0};
    vt[4]  = '{2'd0, 12'h000, 8,  2, 16'h0F0F};
    vt[5]  = '{2'd0, 12'h000, 10, 1, 16'h0F00};
    vt[6]  = '{2'd0, 12'h000, 12, 3, 16'h000F};
    vt[7]  = '{2'd0, 12'h000, 15, 2, 16'h0000};
    vt[8]  = '{2'd1, 12'h000, 5,  2, 16'h0520};
    vt[9]  = '{2'd1, 12'h000, 15, 3, 16'h0F30};
    vt[10] = '{2'd2, 12'h3A7, 7,  1, 16'h03A7};
    vt[11] = '{2'd3, 12'hA5C, 8,  0, 16'h0A5C};
    vt[12] = '{2'd3, 12'hA5C, 3,  2, 16'h0000};

    sif.enable      = 1'b1;
    sif.pattern_sel = 2'd0;
    sif.solid_rgb   = 12'h000;
    reset           = 1'b1;

    // Reset held with enable high, then release straight into a bars frame.
    do_reset(3);
    run_frames(1, 2'd0, 12'h000, 0, "bars");
    ti = pix_t(0, 0, 0);
    check("bars_px0", {16'b0, act[ti].d, act[ti + 1].d}, 32'h0FFF);
    ti = pix_t(0, 14, 0);
    check("bars_px14", {16'b0, act[ti].d, act[ti + 1].d}, 32'h0000);

    for (int i = 0; i < 13; i++) begin
      do_reset(1);
      run_frames(1, vt[i].pat, vt[i].rgb, 0, "vec");
      ti = pix_t(0, vt[i].x, vt[i].y);
      check($sformatf("vec%0d_px", i), {16'b0, act[ti].d, act[ti + 1].d}, {16'b0, vt[i].bytes});
    end

    // Ramp over two back-to-back frames: blue carries the frame count.
    do_reset(1);
    run_frames(2, 2'd1, 12'h000, 0, "ramp2");
    ti = pix_t(1, 5, 2);
    check("ramp_f1_px", {16'b0, act[ti].d, act[ti + 1].d}, 32'h0521);
    check("ramp_fc", {16'b0, sif.frame_count}, 32'd2);

    // Reset mid-active-line, then a clean restart.
    do_reset(1);
    sif.pattern_sel = 2'd1;
    sif.enable      = 1'b1;
    exp_q.delete();
    pop_cnt = 0;
    push_frame(0, 2'd1, 12'h000);
    for (int s = 0; s < 80; s++) step("pre_rst");
    check("mid_href", {31'b0, sif.href}, 32'd1);
    do_reset(1);
    check("rst_fc", {16'b0, sif.frame_count}, 32'd0);
    run_frames(1, 2'd1, 12'h000, 0, "restart");

    // Solid A5C through a capture-style byte pairer.
    run_frames(1, 2'd2, 12'hA5C, 1, "solid");
    wr = 0;
    ph = 0;
    hi = 4'h0;
    for (int t = 0; t < FT; t++) begin
      if (act[t].vs) begin
        wr = 0;
        ph = 0;
      end else if (act[t].hr) begin
        if (ph == 0) begin
          hi = act[t].d[3:0];
        end else begin
          check($sformatf("cap_px%0d", wr), {20'b0, hi, act[t].d}, 32'hA5C);
          wr++;
        end
        ph = 1 - ph;
      end
    end
    check("cap_writes", wr, 32'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
